// File: rtl/systolic_pkg.sv
// Shared constants and types for the 4x4 int8 systolic array feeder.
package systolic_pkg;

  localparam int unsigned N           = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned FEED_CYCLES = 2 * N - 1;
  localparam int unsigned ROW_W       = N * DATA_W;
  localparam int unsigned IDX_W       = $clog2(N);
  localparam int unsigned T_W         = 3;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } feeder_state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } load_sel_e;

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed stream lane: emits vec[t - LANE] inside the 4-wide window, else 0.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic [ROW_W-1:0]  vec_i,
  input  logic [T_W-1:0]    t_i,
  output logic [DATA_W-1:0] elem_o
);

  localparam logic [T_W-1:0] LANE_T = T_W'(LANE);

  logic [DATA_W-1:0] elems [N];
  logic [T_W-1:0]    off;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      elems[k] = vec_i[k*DATA_W +: DATA_W];
    end
  end

  assign off = t_i - LANE_T;

  always_comb begin
    elem_o = '0;
    if ((t_i >= LANE_T) && (off < T_W'(N))) begin
      elem_o = elems[off[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Transmit-side controller for the 4x4 systolic array: buffers A rows / B columns,
// then runs CLEAR -> FEED -> DRAIN -> DONE. Optional counters: SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder_4x4
  import systolic_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     load_sel,
  input  logic [IDX_W-1:0]         load_idx,
  input  logic [ROW_W-1:0]         load_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     clear,
  output logic signed [DATA_W-1:0] a1,
  output logic signed [DATA_W-1:0] a2,
  output logic signed [DATA_W-1:0] a3,
  output logic signed [DATA_W-1:0] a4,
  output logic signed [DATA_W-1:0] b1,
  output logic signed [DATA_W-1:0] b2,
  output logic signed [DATA_W-1:0] b3,
  output logic signed [DATA_W-1:0] b4
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]              run_count,
  output logic [31:0]              busy_cycles
`endif
);

  feeder_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clear_d, done_d, busy_d, feed_d, load_ready_d;
  logic              clear_q, done_q, busy_q, load_ready_q;
  logic              load_fire;

  logic [ROW_W-1:0]  a_rows_q [N];
  logic [ROW_W-1:0]  b_cols_q [N];
  logic [DATA_W-1:0] a_lane   [N];
  logic [DATA_W-1:0] b_lane   [N];
  logic [DATA_W-1:0] a_q      [N];
  logic [DATA_W-1:0] b_q      [N];

  assign load_fire = load_valid && load_ready_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(.LANE(i)) u_a_lane (
      .vec_i  (a_rows_q[i]),
      .t_i    (cnt_q[T_W-1:0]),
      .elem_o (a_lane[i])
    );
    systolic_skew_lane #(.LANE(i)) u_b_lane (
      .vec_i  (b_cols_q[i]),
      .t_i    (cnt_q[T_W-1:0]),
      .elem_o (b_lane[i])
    );
  end

  // Output flags are registered from the current state, so every visible
  // output trails the state register by one cycle (clear at +1, done at +13).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear_d = 1'b0;
    done_d  = 1'b0;
    feed_d  = 1'b0;
    busy_d  = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        clear_d = 1'b1;
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        feed_d = 1'b1;
        if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clear_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_q      <= clear_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      for (int unsigned i = 0; i < N; i++) begin
        a_q[i] <= feed_d ? a_lane[i] : '0;
        b_q[i] <= feed_d ? b_lane[i] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        a_rows_q[i] <= '0;
        b_cols_q[i] <= '0;
      end
    end else if (load_fire) begin
      if (load_sel_e'(load_sel) == SEL_B) begin
        b_cols_q[load_idx] <= load_data;
      end else begin
        a_rows_q[load_idx] <= load_data;
      end
    end
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0] run_count_q;
  logic [31:0] busy_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_count_q   <= '0;
      busy_cycles_q <= '0;
    end else begin
      if (done_q) run_count_q <= run_count_q + 16'd1;
      if (busy_q && (busy_cycles_q != '1)) busy_cycles_q <= busy_cycles_q + 32'd1;
    end
  end

  assign run_count   = run_count_q;
  assign busy_cycles = busy_cycles_q;
`endif

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign clear      = clear_q;
  assign a1         = a_q[0];
  assign a2         = a_q[1];
  assign a3         = a_q[2];
  assign a4         = a_q[3];
  assign b1         = b_q[0];
  assign b2         = b_q[1];
  assign b3         = b_q[2];
  assign b4         = b_q[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Self-checking bench for systolic_feeder_4x4 against a matrix-level reference model.
module tb_systolic_feeder_4x4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        load_sel = 1'b0;
  logic [1:0]  load_idx = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        busy, done, clear;
  logic signed [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0] run_count;
  logic [31:0] busy_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference storage: mA[i][k], mB[k][j]
  int mA [4][4];
  int mB [4][4];
  int sa [4][11];
  int sb [4][11];

  systolic_feeder_4x4 #(.DRAIN_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .clear      (clear),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .a4         (a4),
    .b1         (b1),
    .b2         (b2),
    .b3         (b3),
    .b4         (b4)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .run_count  (run_count),
    .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int get_a(input int i);
    case (i)
      0: return int'(a1);
      1: return int'(a2);
      2: return int'(a3);
      default: return int'(a4);
    endcase
  endfunction

  function automatic int get_b(input int j);
    case (j)
      0: return int'(b1);
      1: return int'(b2);
      2: return int'(b3);
      default: return int'(b4);
    endcase
  endfunction

  function automatic void model_write(input bit sel, input int idx, input logic [31:0] data);
    for (int k = 0; k < 4; k++) begin
      logic signed [7:0] e;
      e = data[8*k +: 8];
      if (sel) mB[k][idx] = int'(e);
      else     mA[idx][k] = int'(e);
    end
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        mA[i][k] = 0;
        mB[i][k] = 0;
      end
  endfunction

  task automatic load_word(input bit sel, input int idx, input logic [31:0] data);
    @(negedge clk);
    load_valid = 1'b1;
    load_sel   = sel;
    load_idx   = idx[1:0];
    load_data  = data;
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready_idle got=%b exp=1", load_ready);
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
    model_write(sel, idx, data);
  endtask

  task automatic load_matrices(input int ta [4][4], input int tb [4][4]);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(ta[i][k]);
      load_word(1'b0, i, w);
    end
    for (int j = 0; j < 4; j++) begin
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(tb[k][j]);
      load_word(1'b1, j, w);
    end
  endtask

  // One full run; optional A-row load in the start cycle, optional start+load_valid injection mid-run.
  task automatic run_check(input string name, input bit cload, input int cidx,
                           input logic [31:0] cdata, input int inject_c);
    int ndone;
    @(negedge clk);
    start = 1'b1;
    if (cload) begin
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_idx   = cidx[1:0];
      load_data  = cdata;
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    load_valid = 1'b0;
    if (cload) model_write(1'b0, cidx, cdata);
    ndone = 0;
    for (int c = 0; c <= 14; c++) begin
      int t;
      @(negedge clk);
      t = c - 2;
      if (inject_c >= 0 && c == inject_c + 1) start = 1'b0;
      if (inject_c >= 0 && c == 12) load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        int ea, eb, aa, ab;
        ea = (c >= 2 && c <= 8 && t - i >= 0 && t - i <= 3) ? mA[i][t-i] : 0;
        eb = (c >= 2 && c <= 8 && t - i >= 0 && t - i <= 3) ? mB[t-i][i] : 0;
        aa = get_a(i);
        ab = get_b(i);
        if (c >= 2 && c <= 12) begin
          sa[i][c-2] = aa;
          sb[i][c-2] = ab;
        end
        checks++;
        if (aa !== ea) begin
          failures++;
          $display("FAIL %s a%0d cycle=%0d got=%0d exp=%0d", name, i + 1, c, aa, ea);
        end
        checks++;
        if (ab !== eb) begin
          failures++;
          $display("FAIL %s b%0d cycle=%0d got=%0d exp=%0d", name, i + 1, c, ab, eb);
        end
      end
      checks++;
      if (clear !== (c == 1)) begin
        failures++;
        $display("FAIL %s clear cycle=%0d got=%b exp=%b", name, c, clear, c == 1);
      end
      checks++;
      if (done !== (c == 13)) begin
        failures++;
        $display("FAIL %s done cycle=%0d got=%b exp=%b", name, c, done, c == 13);
      end
      checks++;
      if (busy !== (c >= 1 && c <= 13)) begin
        failures++;
        $display("FAIL %s busy cycle=%0d got=%b exp=%b", name, c, busy, c >= 1 && c <= 13);
      end
      checks++;
      if (load_ready !== (c >= 13)) begin
        failures++;
        $display("FAIL %s load_ready cycle=%0d got=%b exp=%b", name, c, load_ready, c >= 13);
      end
      if (done === 1'b1) ndone++;
      if (inject_c >= 0 && c == inject_c) begin
        start      = 1'b1;
        load_valid = 1'b1;
        load_sel   = 1'($urandom_range(0, 1));
        load_idx   = 2'($urandom_range(0, 3));
        load_data  = $urandom;
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL %s done_count got=%0d exp=1", name, ndone);
    end
    // Reconstruct the array result from the captured streams and compare with A*B
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int acc, ref_c;
        acc = 0;
        ref_c = 0;
        for (int t = 0; t < 11; t++)
          if (t - j >= 0 && t - i >= 0) acc += sa[i][t-j] * sb[j][t-i];
        for (int k = 0; k < 4; k++) ref_c += mA[i][k] * mB[k][j];
        checks++;
        if (acc !== ref_c) begin
          failures++;
          $display("FAIL %s c%0d%0d got=%0d exp=%0d", name, i + 1, j + 1, acc, ref_c);
        end
      end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({load_ready, busy, done, clear} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {load_ready, busy, done, clear});
    end
    checks++;
    if ({a1, a2, a3, a4, b1, b2, b3, b4} !== 64'd0) begin
      failures++;
      $display("FAIL reset_streams got=%h exp=0", {a1, a2, a3, a4, b1, b2, b3, b4});
    end
    model_zero();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_ready, busy, done, clear} !== 4'b1000) begin
      failures++;
      $display("FAIL idle_ctrl got=%b exp=1000", {load_ready, busy, done, clear});
    end
  endtask

  task automatic test_zero_run();
    run_check("zero_run", 1'b0, 0, '0, -1);
  endtask

  task automatic test_identity();
    int ta [4][4];
    int tb [4][4];
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ta[i][k] = (i == k) ? 1 : 0;
        tb[i][k] = 4 * i + k + 1;
      end
    load_matrices(ta, tb);
    run_check("identity", 1'b0, 0, '0, -1);
  endtask

  task automatic test_skew();
    int ta [4][4];
    int tb [4][4];
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ta[i][k] = 10 * i + k;
        tb[i][k] = -(10 * i + k);
      end
    load_matrices(ta, tb);
    run_check("skew", 1'b0, 0, '0, -1);
  endtask

  task automatic test_min_values();
    int ta [4][4];
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) ta[i][k] = -128;
    load_matrices(ta, ta);
    run_check("min_values", 1'b0, 0, '0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 8; n++)
        load_word(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom);
      run_check("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom, -1);
    end
  endtask

  task automatic test_busy_ignore();
    run_check("busy_ignore", 1'b0, 0, '0, 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL busy_ignore_after got=%b exp=00", {busy, done});
      end
    end
    run_check("busy_ignore_rerun", 1'b0, 0, '0, -1);
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_zero();
    checks++;
    if ({a1, a2, a3, a4, b1, b2, b3, b4} !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_streams got=%h exp=0", {a1, a2, a3, a4, b1, b2, b3, b4});
    end
    checks++;
    if ({busy, clear, done, load_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_ctrl got=%b exp=0000", {busy, clear, done, load_ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d exp=0", ndone);
    end
    run_check("after_reset_zero", 1'b0, 0, '0, -1);
    for (int n = 0; n < 4; n++) load_word(1'b0, n, $urandom);
    for (int n = 0; n < 4; n++) load_word(1'b1, n, $urandom);
    run_check("after_reset_reload", 1'b0, 0, '0, -1);
`ifdef SYSTOLIC_FEEDER_PERF_EN
    checks++;
    if (run_count !== 16'd2) begin
      failures++;
      $display("FAIL perf_run_count got=%0d exp=2", run_count);
    end
    checks++;
    if (busy_cycles !== 32'd26) begin
      failures++;
      $display("FAIL perf_busy_cycles got=%0d exp=26", busy_cycles);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_identity();
    test_skew();
    test_min_values();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_feeder_4x4.md
Name: systolic_feeder_4x4

Overview:
- Transmit-side controller for the 4x4 int8 systolic matmul array.
- Buffers one 4x4 A matrix (as rows) and one 4x4 B matrix (as columns) from a valid/ready load port.
- On start, pulses the array clear and drives the diagonally skewed a1..a4 / b1..b4 streams.
- Waits out the array pipeline, then pulses done so c11..c44 can be sampled.

Parameters:
- N, 4, array dimension; fixed, the block supports only 4.
- DATA_W, 8, element width, signed.
- DRAIN_CYCLES, 4, zero-injection cycles after the last feed cycle; minimum N (3 hops + 1 for the accumulator register).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- load_valid  in  1  load word valid
- load_ready  out  1  load word accepted when high with load_valid
- load_sel  in  1  0 = A row, 1 = B column
- load_idx  in  2  row (A) or column (B) index
- load_data  in  32  four int8 elements; [7:0] = element k=0 … [31:24] = k=3
- start  in  1  single-cycle request to run
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse: array results final
- clear  out  1  array accumulator clear, one-cycle pulse
- a1..a4  out  8 each  signed row streams to the array
- b1..b4  out  8 each  signed column streams to the array

Behaviour:
- Reset (rst low, async) forces the following:
  - State IDLE.
  - All outputs 0, load_ready 0 during reset; load_ready returns to 1 in IDLE.
  - A/B storage zeroed.
- All outputs are registered.
- Storage:
  - A[i][k] written from load_data when load_sel=0, i=load_idx.
  - B[k][j] written when load_sel=1, j=load_idx.
  - A transfer occurs on load_valid && load_ready.
  - load_ready = 1 only in IDLE.
  - Unwritten entries keep their previous value.
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: start=1 → CLEAR. If a load transfer happens in the same cycle as start, the write lands first and FEED uses it.
- CLEAR: clear=1 for exactly this cycle; streams 0; → FEED.
- FEED: counter t = 0..2N-2 (7 cycles), then → DRAIN.
  - a(i+1) = A[i][t-i] if 0 ≤ t-i ≤ 3, else 0.
  - b(j+1) = B[t-j][j] if 0 ≤ t-j ≤ 3, else 0.
- DRAIN: streams 0 for DRAIN_CYCLES cycles → DONE.
- DONE: done=1 for one cycle, streams 0 → IDLE.
- Latency: done is asserted exactly 1 + 7 + DRAIN_CYCLES + 1 cycles after the start sample (13 at defaults).
- busy = (state != IDLE); it drops the cycle after done.
- start while busy: ignored, no queuing.
- load_valid while busy: not accepted (load_ready=0); data held off by the sender.
- Reset mid-run: immediate return to IDLE, streams and clear forced 0, storage zeroed, no done.
- No arithmetic in the block; elements are passed unmodified as two's-complement int8.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_PERF_EN.
- When defined:
  - Adds output run_count [15:0], reset 0.
  - Increments by 1 on each done pulse.
  - Wraps 0xFFFF → 0.
  - Adds output busy_cycles [31:0], reset 0, incremented every cycle busy=1 and saturating at 0xFFFFFFFF.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package systolic_pkg holds:
  - N, DATA_W, ACC_W=32.
  - FEED_CYCLES = 2N-1.
  - The feeder state enum (IDLE, CLEAR, FEED, DRAIN, DONE).
  - The load_sel encodings.
- One sub-module: systolic_skew_lane.
  - Given a lane index, the 4-element vector and t, it outputs the element or 0 per the window rule.
  - Instantiated 8 times (4 A lanes, 4 B lanes).

Test Plan:
- Reset then idle → all outputs 0, busy 0, load_ready 1; start with all-zero storage → done at cycle 13, c all 0.
- A = identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} loaded as columns, start; array connected → clear pulse at cycle 1, done at cycle 13, c == B.
- Skew check, A[i][k]=10i+k: a1 at FEED t=0..3 = 0,1,2,3; a2 at t=0 = 0, t=1..4 = 10..13; a4 at t=3 = 30, t=6 = 33, t=7 = 0.
- All elements -128 in A and B → every c = 65536; b4 at t=3 = -128.
- Start pulsed at FEED t=2 and load_valid held high → both ignored (load_ready 0), done still at cycle 13 exactly once.
- rst low at FEED t=4 → streams 0 and busy 0 asynchronously, no done; reload and restart produce correct results. With SYSTOLIC_FEEDER_PERF_EN, two runs → run_count=2, busy_cycles=26.
